// File: rtl/countdown_scheduler.sv
// Round-robin scheduler sharing one down-counter among NREQ requesters.
// Grants one owner at a time, counts its interval down on tick, and pulses done on expiry.
module countdown_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done,
    output logic [1:0]            dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [PW-1:0]    ptr, ptr_next;
    logic [PW-1:0]    owner, owner_next;
    logic [NREQ-1:0]  grant_next, done_next;
    logic [WIDTH-1:0] count_next;
    logic [PW-1:0]    sel_idx, cand;
    logic             sel_valid;
    int               scan_idx;

    // Wrapping scan starting at ptr; the first set request wins.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            cand = PW'(scan_idx);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        grant_next = grant;
        done_next  = '0;
        count_next = count;
        case (state)
            S_IDLE: begin
                if (sel_valid) begin
                    state_next          = S_RUN;
                    owner_next          = sel_idx;
                    grant_next          = '0;
                    grant_next[sel_idx] = 1'b1;
                    count_next          = load_val[int'(sel_idx)*WIDTH +: WIDTH];
                end
            end
            S_RUN: begin
                // Abort takes priority over expiry: a dropped request never sees done.
                if (!req[owner]) begin
                    state_next = S_IDLE;
                    grant_next = '0;
                    count_next = '0;
                end else if (count == '0) begin
                    state_next       = S_DONE;
                    done_next[owner] = 1'b1;
                end else if (tick) begin
                    count_next = count - WIDTH'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                grant_next = '0;
                ptr_next   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            done  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            owner <= owner_next;
            grant <= grant_next;
            done  <= done_next;
            count <= count_next;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
